// File: rtl/dtt_xbar_pkg.sv
// Types and constants shared by the crossbar switch and its per-port egress queues.
package dtt_xbar_pkg;

  localparam int unsigned XbDataWidth = 32;
  localparam int unsigned NumPorts    = 4;

  typedef logic [XbDataWidth-1:0] xb_beat_t;

endpackage

// File: rtl/dtt_xbar_egress_queue_if.sv
// Beat-in / beat-out signals of one egress queue; master drives the queue, slave is the queue.
interface dtt_xbar_egress_queue_if
  import dtt_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XbDataWidth
);

  logic [DATA_WIDTH-1:0] xb_data;
  logic                  xb_valid;
  logic [DATA_WIDTH-1:0] deq_data;
  logic                  deq_valid;
  logic                  deq_ready;

  modport master (
    output xb_data,
    output xb_valid,
    output deq_ready,
    input  deq_data,
    input  deq_valid
  );

  modport slave (
    input  xb_data,
    input  xb_valid,
    input  deq_ready,
    output deq_data,
    output deq_valid
  );

endinterface

// File: rtl/dtt_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and registered count/full/empty.
module dtt_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o,
  output logic [CntW-1:0]  count_next_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;
  logic [Width-1:0] mem_q [Depth];

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign pop_ok  = pop_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    count_d  = count_q + {{(CntW-1){1'b0}}, push_ok} - {{(CntW-1){1'b0}}, pop_ok};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately not reset; the read port masks stale contents while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o      = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/dtt_xbar_egress_queue.sv
// Per-output-port egress buffer behind the crossbar: absorbs beats, drains over valid/ready,
// drops and counts beats that find no free slot, and tracks the occupancy high-water mark.
module dtt_xbar_egress_queue
  import dtt_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XbDataWidth,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dtt_xbar_egress_queue_if.slave bus,
  input  logic                 clr_stats_i,
  output logic [CW-1:0]        count_o,
  output logic                 almost_full_o,
  output logic                 full_o,
  output logic                 drop_pulse_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [CW-1:0]        hwm_o
);

  logic                  fifo_empty, fifo_full;
  logic                  deq_valid;
  logic                  push, pop, drop;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  almost_full_q, almost_full_d;
  logic                  drop_pulse_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]         hwm_q, hwm_d;

  assign deq_valid = ~fifo_empty;
  assign pop       = deq_valid & bus.deq_ready;
  assign push      = bus.xb_valid & (~fifo_full | pop);
  assign drop      = bus.xb_valid & fifo_full & ~pop;

  dtt_sync_fifo #(
    .Width (DATA_WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (bus.xb_data),
    .rdata_o      (head_data),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (count_o),
    .count_next_o (count_next)
  );

  always_comb begin
    almost_full_d = (count_next >= CW'(AF_LEVEL));
    drop_cnt_d    = drop_cnt_q;
    hwm_d         = (count_next > hwm_q) ? count_next : hwm_q;
    // Clear wins over a drop in the same cycle; drop_pulse is unaffected.
    if (clr_stats_i) begin
      drop_cnt_d = '0;
      hwm_d      = count_next;
    end else if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      drop_cnt_q    <= '0;
      hwm_q         <= '0;
    end else begin
      almost_full_q <= almost_full_d;
      drop_pulse_q  <= drop;
      drop_cnt_q    <= drop_cnt_d;
      hwm_q         <= hwm_d;
    end
  end

  assign bus.deq_valid = deq_valid;
  assign bus.deq_data  = head_data;
  assign almost_full_o = almost_full_q;
  assign full_o        = fifo_full;
  assign drop_pulse_o  = drop_pulse_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign hwm_o         = hwm_q;

endmodule

// File: tb/tb_dtt_xbar_egress_queue.sv
// Directed bench for dtt_xbar_egress_queue with a queue scoreboard for the random drain phase.
module tb_dtt_xbar_egress_queue;
  import dtt_xbar_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NBEATS = 1000;
  localparam int unsigned CYC_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_stats;
  logic [3:0]  count;
  logic        almost_full;
  logic        full;
  logic        drop_pulse;
  logic [15:0] drop_cnt;
  logic [3:0]  hwm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtt_xbar_egress_queue_if #(.DATA_WIDTH(XbDataWidth)) bus ();

  dtt_xbar_egress_queue #(
    .DATA_WIDTH (XbDataWidth),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (6),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .clr_stats_i   (clr_stats),
    .count_o       (count),
    .almost_full_o (almost_full),
    .full_o        (full),
    .drop_pulse_o  (drop_pulse),
    .drop_cnt_o    (drop_cnt),
    .hwm_o         (hwm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    xb_beat_t sb[$];
    xb_beat_t data;
    int       pushed;
    int       cyc;
    bit       v;
    bit       r;

    $display("egress queue bench, port 0 of %0d", NumPorts);
    bus.xb_valid  = 1'b1;
    bus.xb_data   = 32'h5555_5555;
    bus.deq_ready = 1'b0;
    clr_stats     = 1'b0;

    // T1: reset held with beats offered
    repeat (5) step();
    check("t1_deq_valid", bus.deq_valid, 0);
    check("t1_deq_data", bus.deq_data, 0);
    check("t1_count", count, 0);
    check("t1_full", full, 0);
    check("t1_drop_cnt", drop_cnt, 0);
    check("t1_hwm", hwm, 0);
    rst_n        = 1'b1;
    bus.xb_data  = 32'h1234_5678;
    step();
    bus.xb_valid = 1'b0;
    check("t1_first_valid", bus.deq_valid, 1);
    check("t1_first_data", bus.deq_data, 32'h1234_5678);
    check("t1_first_count", count, 1);
    check("t1_first_hwm", hwm, 1);
    bus.deq_ready = 1'b1;
    step();
    check("t1_pop_count", count, 0);
    check("t1_pop_valid", bus.deq_valid, 0);
    check("t1_pop_data_mask", bus.deq_data, 0);

    // T2: two back-to-back beats drained in order
    bus.xb_valid = 1'b1;
    bus.xb_data  = 32'hAAAA_BBBB;
    check("t2_no_fallthrough", bus.deq_valid, 0);
    step();
    bus.xb_data = 32'hCCCC_DDDD;
    check("t2_data0", bus.deq_data, 32'hAAAA_BBBB);
    check("t2_count0", count, 1);
    step();
    bus.xb_valid = 1'b0;
    check("t2_data1", bus.deq_data, 32'hCCCC_DDDD);
    check("t2_count1", count, 1);
    step();
    check("t2_count_end", count, 0);
    check("t2_valid_end", bus.deq_valid, 0);

    // T3: overflow with the consumer stalled
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.xb_valid = 1'b1;
      bus.xb_data  = 32'(i);
      step();
      check("t3_count", count, (i < 8) ? i + 1 : 8);
      check("t3_full", full, (i >= 7) ? 1 : 0);
      check("t3_almost_full", almost_full, (i >= 5) ? 1 : 0);
      check("t3_drop_pulse", drop_pulse, (i >= 8) ? 1 : 0);
      check("t3_drop_cnt", drop_cnt, (i >= 8) ? i - 7 : 0);
    end
    bus.xb_valid = 1'b0;
    step();
    check("t3_drop_pulse_end", drop_pulse, 0);
    check("t3_drop_cnt_end", drop_cnt, 2);
    check("t3_hwm", hwm, 8);
    check("t3_head", bus.deq_data, 0);

    // T4: full queue, simultaneous pop and push
    bus.deq_ready = 1'b1;
    bus.xb_valid  = 1'b1;
    bus.xb_data   = 32'h1111_2222;
    step();
    bus.xb_valid = 1'b0;
    check("t4_count", count, 8);
    check("t4_full", full, 1);
    check("t4_drop_pulse", drop_pulse, 0);
    check("t4_drop_cnt", drop_cnt, 2);
    for (int i = 1; i < 9; i++) begin
      check("t4_drain_valid", bus.deq_valid, 1);
      check("t4_drain_data", bus.deq_data, (i < 8) ? 32'(i) : 32'h1111_2222);
      step();
    end
    check("t4_empty_valid", bus.deq_valid, 0);
    check("t4_empty_count", count, 0);

    // T5: random stall and offer pattern against a scoreboard
    pushed = 0;
    cyc    = 0;
    while ((pushed < NBEATS || sb.size() != 0) && cyc < CYC_LIMIT) begin
      check("t5_valid", bus.deq_valid, (sb.size() != 0) ? 1 : 0);
      check("t5_count", count, sb.size());
      if (sb.size() != 0) check("t5_data", bus.deq_data, sb[0]);
      v    = (pushed < NBEATS) && ($urandom_range(1, 0) == 1) && (sb.size() < DEPTH);
      r    = ($urandom_range(1, 0) == 1);
      data = $urandom;
      bus.xb_valid  = v;
      bus.xb_data   = data;
      bus.deq_ready = r;
      step();
      if (r && sb.size() != 0) void'(sb.pop_front());
      if (v) begin
        sb.push_back(data);
        pushed++;
      end
      cyc++;
    end
    bus.xb_valid  = 1'b0;
    bus.deq_ready = 1'b0;
    check("t5_left", (NBEATS - pushed) + sb.size(), 0);
    check("t5_drop_cnt", drop_cnt, 2);
    check("t5_count_end", count, 0);

    // T6: clear during a drop, then async reset mid-drain
    for (int i = 0; i < 8; i++) begin
      bus.xb_valid = 1'b1;
      bus.xb_data  = 32'hA0 + 32'(i);
      step();
    end
    check("t6_full", full, 1);
    check("t6_drop_cnt_pre", drop_cnt, 2);
    clr_stats = 1'b1;
    step();
    clr_stats    = 1'b0;
    bus.xb_valid = 1'b0;
    check("t6_drop_cnt_clr", drop_cnt, 0);
    check("t6_drop_pulse", drop_pulse, 1);
    check("t6_hwm", hwm, 8);
    check("t6_count", count, 8);
    step();
    check("t6_drop_pulse_off", drop_pulse, 0);
    check("t6_drop_cnt_hold", drop_cnt, 0);
    bus.deq_ready = 1'b1;
    step();
    step();
    check("t6_count_drain", count, 6);
    check("t6_head_drain", bus.deq_data, 32'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_valid", bus.deq_valid, 0);
    check("t6_rst_data", bus.deq_data, 0);
    check("t6_rst_full", full, 0);
    check("t6_rst_af", almost_full, 0);
    check("t6_rst_hwm", hwm, 0);
    bus.deq_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t6_post_count", count, 0);
    check("t6_post_drop_cnt", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
